div_result_display: RTL and testbench
=====================================

# div_result_display

Downstream result stage of the calculator divider: captures the 4-bit quotient, 4-bit remainder and error flag when the divider controller signals completion. It converts each operand to two BCD digits with a sequential shift-add-3 (double-dabble) engine and drives a 4-digit, time-multiplexed, active-low seven-segment display. The digits are quotient tens, quotient ones, remainder tens and remainder ones, from left to right.

## Interface
- REFRESH_BITS, default 18: width of the free-running refresh counter. The top 2 bits select the digit being scanned.
- CLK  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous and active-high.
- valid  input  1  one-cycle result-ready pulse from the divider controller.
- Q  input  4  quotient, unsigned 0..15.
- R  input  4  remainder, unsigned 0..15.
- error  input  1  divide-by-zero flag, sampled together with Q and R.
- busy  output  1  conversion in progress. While high, valid is ignored.
- upd  output  1  one-cycle pulse on the first cycle that new digits are displayed.
- an  output  4  digit anodes, active-low, one-hot. an[3] is the leftmost digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

## Operation
- FSM states: IDLE, CONV_Q, CONV_R, LOAD.
- IDLE with valid=1: register Q, R and error.
  - If error=1, go to LOAD.
  - Otherwise, clear the 8-bit BCD accumulator and go to CONV_Q.
- CONV_Q runs 4 iterations, one per cycle, on the shift register {bcd[7:0], bin[3:0]}, with bin loaded from Q. Each iteration:
  - Add 3 to every BCD nibble that is >= 5.
  - Then shift the whole register left by 1.
- After 4 iterations, store the quotient tens/ones digits and go to CONV_R. CONV_R repeats the same 4 iterations on R, then goes to LOAD.
- Width rule: for inputs up to 15, the tens nibble is only ever 0 or 1. The accumulator is still kept 8 bits wide.
- LOAD: copy the converted digits, or the error pattern, into the display registers d3..d0, then return to IDLE.
- Digit mapping: d3 = Q tens, d2 = Q ones, d1 = R tens, d0 = R ones.
- Error pattern: d3 = 'E', d2 = 'r', d1 = 'r', d0 = blank. Q and R are ignored in this case.
- Digit codes are 0-9, 'E', 'r' and blank. Any undefined code displays as blank.
- Scan: the refresh counter increments every cycle and wraps. Its top 2 bits k select digit d[k]; an[k]=0 and seg = decode(d[k]).
- The display registers hold their value until the next LOAD. Scanning never stops.

## Timing
- Reset values:
  - FSM = IDLE, busy=0, upd=0.
  - d3..d0 = blank, refresh counter = 0.
  - an=4'b1110, seg=7'h7F.
- Cycle 0 is the cycle in which valid=1 is sampled in IDLE.
- Normal result:
  - busy is high in cycles 1-9 (CONV_Q = 1-4, CONV_R = 5-8, LOAD = 9).
  - The new digits are visible, and upd=1, in cycle 10.
- Error result:
  - busy is high in cycle 1 only (LOAD).
  - The new digits are visible, and upd=1, in cycle 2.
- valid while busy=1 is dropped with no effect. valid in the same cycle as upd is accepted, because the FSM is already in IDLE.
- rst asserted mid-conversion: on the next edge the FSM returns to IDLE and the display shows blank. The partially converted result is discarded.
- an and seg are registered. They change one cycle after the refresh counter's top bits change.

## Configuration
- LEADING_ZERO_BLANK_EN
  - Defined: during LOAD, d3 is blanked when Q tens = 0 and d1 is blanked when R tens = 0. The error pattern is unaffected.
  - Undefined: tens digits always show, including a leading 0.

## Structure
- Shared package div_disp_pkg contains:
  - The state enum.
  - The 4-bit digit codes (0-9, DIG_E, DIG_R, DIG_BLANK).
  - The active-low segment constants.
  - The number of double-dabble iterations (4).
- One sub-module, seg7_decode: a combinational mapping from a 4-bit digit code to 7 active-low segments, using the package constants.

## Test plan
- With rst, scan check at REFRESH_BITS=4: an cycles 1110 -> 1101 -> 1011 -> 0111, every 4 cycles each, and seg is 7'h7F on all digits.
- valid with Q=7, R=3: busy is high for 9 cycles, upd fires in cycle 10, and the digits read 0,7,0,3. With LEADING_ZERO_BLANK_EN they read blank,7,blank,3.
- valid with Q=15, R=12: the digits read 1,5,1,2.
- valid with error=1 and Q=4: upd fires in cycle 2 and the digits read E,r,r,blank.
- Busy-drop: valid with Q=9,R=1, then valid with Q=2,R=2 in cycle 3. The display shows 0,9,0,1, and only one upd pulse occurs.
- Reset mid-op: valid with Q=8,R=0, then rst in cycle 5. The display is blank, busy=0, and there is no upd. A subsequent valid with Q=1,R=1 displays 0,1,0,1.

Source files
------------

// File: rtl/div_disp_pkg.sv
// Shared types and constants for the divider result display.
// State encoding, digit codes, active-low segment patterns and the
// double-dabble step used by the converter.
package div_disp_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV_Q = 2'd1,
      CONV_R = 2'd2,
      LOAD   = 2'd3
   } state_t;

   // Digit codes: 0-9 are their own values, the rest are glyphs.
   localparam logic [3:0] DIG_E     = 4'hA;
   localparam logic [3:0] DIG_R     = 4'hB;
   localparam logic [3:0] DIG_BLANK = 4'hF;

   // Segment patterns {g,f,e,d,c,b,a}, a 0 lights the segment.
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_R     = 7'h2F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // One iteration per input bit of the 4-bit operands.
   localparam int DD_ITERS = 4;

   // One shift-add-3 iteration on {bcd[7:0], bin[3:0]}.
   function automatic logic [11:0] dd_step(input logic [11:0] sr);
      logic [11:0] adj;
      adj = sr;
      if (adj[11:8] >= 4'd5) adj[11:8] = adj[11:8] + 4'd3;
      if (adj[7:4] >= 4'd5)  adj[7:4]  = adj[7:4] + 4'd3;
      return {adj[10:0], 1'b0};
   endfunction

endpackage

// File: rtl/div_result_display_if.sv
// Result handshake and display bus of the divider result stage.
// valid/Q/R/error come from the divider controller; valid is a one-cycle
// pulse honoured only while busy is low, and a pulse seen while busy is
// high is dropped. state_dbg mirrors the FSM state for observation.
interface div_result_display_if;
   import div_disp_pkg::*;

   logic       valid;
   logic [3:0] Q;
   logic [3:0] R;
   logic       error;
   logic       busy;
   logic       upd;
   logic [3:0] an;
   logic [6:0] seg;
   state_t     state_dbg;

   modport master (
      output valid, Q, R, error,
      input  busy, upd, an, seg, state_dbg
   );

   modport slave (
      input  valid, Q, R, error,
      output busy, upd, an, seg, state_dbg
   );

endinterface

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-low seven-segment mapping.
// Any code outside 0-9, E and r shows as blank.
module seg7_decode
   import div_disp_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);

   // Table lookup on the digit code.
   always_comb begin
      seg_o = SEG_BLANK;
      case (digit_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         DIG_E:   seg_o = SEG_E;
         DIG_R:   seg_o = SEG_R;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/div_result_display.sv
// Divider result display: captures quotient/remainder/error, converts both
// operands to BCD with a sequential double-dabble engine and scans a
// 4-digit active-low seven-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks a zero tens digit at load.
module div_result_display
   import div_disp_pkg::*;
#(
   parameter int REFRESH_BITS = 18
) (
   input logic                 CLK,
   input logic                 rst,
   div_result_display_if.slave bus
);

   localparam logic [1:0] LAST_ITER = 2'(DD_ITERS - 1);

   state_t      state_q;
   logic [1:0]  iter_q;
   logic [11:0] sr_q;
   logic [11:0] sr_d;
   logic [3:0]  r_q;
   logic        err_q;
   logic [3:0]  qt_q, qo_q;
   logic [3:0]  d3_q, d2_q, d1_q, d0_q;
   logic        busy_q, upd_q;

   logic [REFRESH_BITS-1:0] ref_q;
   logic [1:0]              scan_k;
   logic [3:0]              scan_digit;
   logic [6:0]              seg_d;
   logic [3:0]              an_q;
   logic [6:0]              seg_q;

   // Next value of the shift register after one shift-add-3 iteration.
   always_comb begin
      sr_d = dd_step(sr_q);
   end

   // Control FSM: capture, convert Q then R, load the display registers.
   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q <= IDLE;
         iter_q  <= 2'd0;
         sr_q    <= 12'd0;
         r_q     <= 4'd0;
         err_q   <= 1'b0;
         qt_q    <= 4'd0;
         qo_q    <= 4'd0;
         d3_q    <= DIG_BLANK;
         d2_q    <= DIG_BLANK;
         d1_q    <= DIG_BLANK;
         d0_q    <= DIG_BLANK;
         busy_q  <= 1'b0;
         upd_q   <= 1'b0;
      end else begin
         upd_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.valid) begin
                  r_q    <= bus.R;
                  err_q  <= bus.error;
                  sr_q   <= {8'h00, bus.Q};
                  iter_q <= 2'd0;
                  busy_q <= 1'b1;
                  state_q <= bus.error ? LOAD : CONV_Q;
               end
            end
            CONV_Q: begin
               sr_q   <= sr_d;
               iter_q <= iter_q + 2'd1;
               if (iter_q == LAST_ITER) begin
                  // Keep the quotient digits and restart on the remainder.
                  qt_q    <= sr_d[11:8];
                  qo_q    <= sr_d[7:4];
                  sr_q    <= {8'h00, r_q};
                  iter_q  <= 2'd0;
                  state_q <= CONV_R;
               end
            end
            CONV_R: begin
               sr_q   <= sr_d;
               iter_q <= iter_q + 2'd1;
               if (iter_q == LAST_ITER) begin
                  iter_q  <= 2'd0;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               if (err_q) begin
                  d3_q <= DIG_E;
                  d2_q <= DIG_R;
                  d1_q <= DIG_R;
                  d0_q <= DIG_BLANK;
               end else begin
`ifdef LEADING_ZERO_BLANK_EN
                  d3_q <= (qt_q == 4'd0) ? DIG_BLANK : qt_q;
                  d1_q <= (sr_q[11:8] == 4'd0) ? DIG_BLANK : sr_q[11:8];
`else
                  d3_q <= qt_q;
                  d1_q <= sr_q[11:8];
`endif
                  d2_q <= qo_q;
                  d0_q <= sr_q[7:4];
               end
               busy_q  <= 1'b0;
               upd_q   <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Digit selected by the top two refresh-counter bits.
   always_comb begin
      scan_k     = ref_q[REFRESH_BITS-1 -: 2];
      scan_digit = DIG_BLANK;
      case (scan_k)
         2'd0: scan_digit = d0_q;
         2'd1: scan_digit = d1_q;
         2'd2: scan_digit = d2_q;
         2'd3: scan_digit = d3_q;
         default: scan_digit = DIG_BLANK;
      endcase
   end

   seg7_decode u_seg7_decode (
      .digit_i (scan_digit),
      .seg_o   (seg_d)
   );

   // Free-running refresh counter and registered anode/segment drive.
   always_ff @(posedge CLK) begin
      if (rst) begin
         ref_q <= '0;
         an_q  <= 4'b1110;
         seg_q <= SEG_BLANK;
      end else begin
         ref_q <= ref_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
         an_q  <= ~(4'b0001 << scan_k);
         seg_q <= seg_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.upd       = upd_q;
   assign bus.an        = an_q;
   assign bus.seg       = seg_q;
   assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_div_result_display.sv
// Bench for div_result_display: table of directed results plus hand-written
// sequences for busy-drop, back-to-back acceptance and reset mid-conversion.
module tb_div_result_display;
   import div_disp_pkg::*;

   // Clock / reset
   logic CLK = 1'b0;
   logic rst = 1'b1;
   always #5 CLK = ~CLK;

   div_result_display_if bus ();

   div_result_display #(.REFRESH_BITS(4)) dut (
      .CLK (CLK),
      .rst (rst),
      .bus (bus)
   );

   // Expected segment glyphs, written out by hand.
   localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
   localparam logic [6:0] S5 = 7'h12, S7 = 7'h78, S9 = 7'h10;
   localparam logic [6:0] SE = 7'h06, SR = 7'h2F, BL = 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] Z = 7'h7F;
`else
   localparam logic [6:0] Z = 7'h40;
`endif

   typedef struct {
      logic [3:0]  q;
      logic [3:0]  r;
      logic        err;
      int          exp_upd;
      int          exp_busy;
      logic [27:0] exp_disp;
   } vec_t;

   vec_t vecs [6];

   // Scoreboard
   logic [27:0] exp_q [$];
   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Driver: pulse valid, then watch busy/upd for a bounded window.
   // Cycle numbering: cycle 0 is the cycle valid is sampled.
   task automatic watch(input logic [3:0] q, input logic [3:0] r, input logic e,
                        input int v2_cycle, input logic [3:0] q2, input logic [3:0] r2,
                        input int rst_cycle,
                        output int upd_cycle, output int upd_count, output int busy_count);
      upd_cycle  = -1;
      upd_count  = 0;
      busy_count = 0;
      @(negedge CLK);
      bus.valid = 1'b1; bus.Q = q; bus.R = r; bus.error = e;
      @(negedge CLK);
      bus.valid = 1'b0;
      for (int c = 1; c <= 24; c++) begin
         if (bus.upd === 1'b1) begin
            if (upd_cycle < 0) upd_cycle = c;
            upd_count++;
         end
         if (bus.busy === 1'b1) busy_count++;
         bus.valid = 1'b0;
         rst = 1'b0;
         if (c == v2_cycle) begin
            bus.valid = 1'b1; bus.Q = q2; bus.R = r2; bus.error = 1'b0;
         end
         if (c == rst_cycle) rst = 1'b1;
         @(negedge CLK);
      end
      rst = 1'b0;
   endtask

   // Collect one full scan, digit by digit, keyed on the active anode.
   task automatic read_display(output logic [27:0] w);
      w = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         case (bus.an)
            4'b1110: w[6:0]   = bus.seg;
            4'b1101: w[13:7]  = bus.seg;
            4'b1011: w[20:14] = bus.seg;
            4'b0111: w[27:21] = bus.seg;
            default: ;
         endcase
      end
   endtask

   task automatic check_display(input string nm);
      logic [27:0] got;
      logic [27:0] want;
      read_display(got);
      want = exp_q.pop_front();
      check(nm, {4'h0, got}, {4'h0, want});
   endtask

   initial begin
      int uc, un, bc;
      logic [3:0] want_an;

      vecs[0] = '{q: 4'd7,  r: 4'd3,  err: 1'b0, exp_upd: 10, exp_busy: 9, exp_disp: {Z,  S7, Z,  S3}};
      vecs[1] = '{q: 4'd15, r: 4'd12, err: 1'b0, exp_upd: 10, exp_busy: 9, exp_disp: {S1, S5, S1, S2}};
      vecs[2] = '{q: 4'd4,  r: 4'd0,  err: 1'b1, exp_upd: 2,  exp_busy: 1, exp_disp: {SE, SR, SR, BL}};
      vecs[3] = '{q: 4'd0,  r: 4'd0,  err: 1'b0, exp_upd: 10, exp_busy: 9, exp_disp: {Z,  S0, Z,  S0}};
      vecs[4] = '{q: 4'd10, r: 4'd9,  err: 1'b0, exp_upd: 10, exp_busy: 9, exp_disp: {S1, S0, Z,  S9}};
      vecs[5] = '{q: 4'd5,  r: 4'd15, err: 1'b0, exp_upd: 10, exp_busy: 9, exp_disp: {Z,  S5, S1, S5}};

      bus.valid = 1'b0; bus.Q = 4'd0; bus.R = 4'd0; bus.error = 1'b0;

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge CLK);
      check("rst_an",    {28'h0, bus.an},   32'hE);
      check("rst_seg",   {25'h0, bus.seg},  32'h7F);
      check("rst_busy",  {31'h0, bus.busy}, 32'h0);
      check("rst_upd",   {31'h0, bus.upd},  32'h0);
      check("rst_state", {30'h0, bus.state_dbg}, {30'h0, IDLE});

      // Scan sequence from reset release: each anode for 4 cycles.
      rst = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge CLK);
         want_an = ~(4'b0001 << (((i - 1) >> 2) & 3));
         check($sformatf("scan_an_%0d", i), {28'h0, bus.an}, {28'h0, want_an});
         check($sformatf("scan_seg_%0d", i), {25'h0, bus.seg}, 32'h7F);
      end

      // Table-driven results
      foreach (vecs[i]) begin
         exp_q.push_back(vecs[i].exp_disp);
         watch(vecs[i].q, vecs[i].r, vecs[i].err, -1, 4'd0, 4'd0, -1, uc, un, bc);
         check($sformatf("v%0d_upd_cycle", i), uc, vecs[i].exp_upd);
         check($sformatf("v%0d_upd_count", i), un, 1);
         check($sformatf("v%0d_busy_cycles", i), bc, vecs[i].exp_busy);
         check_display($sformatf("v%0d_display", i));
      end

      // Busy-drop: second valid in cycle 3 is ignored.
      exp_q.push_back({Z, S9, Z, S1});
      watch(4'd9, 4'd1, 1'b0, 3, 4'd2, 4'd2, -1, uc, un, bc);
      check("drop_upd_cycle", uc, 10);
      check("drop_upd_count", un, 1);
      check("drop_busy", bc, 9);
      check_display("drop_display");

      // valid together with upd is accepted.
      exp_q.push_back({Z, S2, Z, S0});
      watch(4'd6, 4'd1, 1'b0, 10, 4'd2, 4'd0, -1, uc, un, bc);
      check("b2b_upd_count", un, 2);
      check("b2b_busy", bc, 18);
      check_display("b2b_display");

      // Reset mid-conversion discards the result.
      exp_q.push_back({BL, BL, BL, BL});
      watch(4'd8, 4'd0, 1'b0, -1, 4'd0, 4'd0, 5, uc, un, bc);
      check("rmid_upd_count", un, 0);
      check("rmid_busy", bc, 5);
      check("rmid_busy_now", {31'h0, bus.busy}, 32'h0);
      check("rmid_state", {30'h0, bus.state_dbg}, {30'h0, IDLE});
      check_display("rmid_display");

      exp_q.push_back({Z, S1, Z, S1});
      watch(4'd1, 4'd1, 1'b0, -1, 4'd0, 4'd0, -1, uc, un, bc);
      check("post_upd_cycle", uc, 10);
      check("post_upd_count", un, 1);
      check_display("post_display");

      check("sb_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
